// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan controller: FSM encoding,
// blank segment pattern and the all-anodes-off helper.
package seg7_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BLANK = 2'd1;
    localparam logic [1:0] ST_DRIVE = 2'd2;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam int         MAX_DIG = 8;

    // Anodes are active-low, so "all off" is a vector of n ones.
    function automatic logic [MAX_DIG-1:0] com_off(input int n);
        logic [MAX_DIG-1:0] v;
        v = '0;
        for (int k = 0; k < MAX_DIG; k++) begin
            if (k < n) v[k] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/SEG7_LUT.sv
// Hex digit to active-low 7-segment pattern (bit 6 = g ... bit 0 = a).
module SEG7_LUT (
    input  logic [3:0] iDIG,
    output logic [6:0] oSEG
);

    always_comb begin
        case (iDIG)
            4'h0: oSEG = 7'b1000000;
            4'h1: oSEG = 7'b1111001;
            4'h2: oSEG = 7'b0100100;
            4'h3: oSEG = 7'b0110000;
            4'h4: oSEG = 7'b0011001;
            4'h5: oSEG = 7'b0010010;
            4'h6: oSEG = 7'b0000010;
            4'h7: oSEG = 7'b1111000;
            4'h8: oSEG = 7'b0000000;
            4'h9: oSEG = 7'b0011000;
            4'hA: oSEG = 7'b0001000;
            4'hB: oSEG = 7'b0000011;
            4'hC: oSEG = 7'b1000110;
            4'hD: oSEG = 7'b0100001;
            4'hE: oSEG = 7'b0000110;
            default: oSEG = 7'b0001110;
        endcase
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed N-digit common-anode scan controller with blanking gaps,
// frame-synchronous double buffering and optional leading-zero suppression.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int N_DIG = 4,
    parameter int DIV   = 50000,
    parameter int BLANK = 4
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic               iEN,
    input  logic [4*N_DIG-1:0] iDATA,
    input  logic [N_DIG-1:0]   iDP,
    input  logic               iLOAD,
    input  logic               iLZS,
    output logic [6:0]         oSEG,
    output logic               oDP,
    output logic [N_DIG-1:0]   oCOM,
    output logic               oFRAME,
    output logic [1:0]         dbg_state
);

    localparam int CW = $clog2(DIV);
    localparam int IW = (N_DIG > 2) ? $clog2(N_DIG) : 1;
    localparam logic [MAX_DIG-1:0] COM_ALL = com_off(N_DIG);
    localparam logic [N_DIG-1:0]   COM_OFF = COM_ALL[N_DIG-1:0];

    logic [1:0]         state;
    logic [CW-1:0]      count;
    logic [IW-1:0]      idx;
    logic [4*N_DIG-1:0] act_data, pend_data;
    logic [N_DIG-1:0]   act_dp, pend_dp;
    logic               pend_valid;

    logic               slot_end, frame_end, boundary;
    logic [3:0]         nib;
    logic               dp_sel;
    logic [6:0]         lut_seg;
    logic [N_DIG-1:0]   supp;
    logic               zero_run;
    logic [6:0]         nxt_seg;
    logic               nxt_dp;
    logic [N_DIG-1:0]   nxt_com;

    assign dbg_state = state;
    assign slot_end  = (state == ST_DRIVE) && (count == CW'(DIV - 1));
    assign frame_end = slot_end && (idx == IW'(N_DIG - 1));
    // A frame starts whenever the scan enters BLANK on digit 0.
    assign boundary  = iEN && ((state == ST_IDLE) || frame_end);

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state <= ST_IDLE;
            count <= '0;
            idx   <= '0;
        end else if (!iEN) begin
            state <= ST_IDLE;
            count <= '0;
            idx   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state <= ST_BLANK;
                    count <= '0;
                    idx   <= '0;
                end
                ST_BLANK: begin
                    if (count == CW'(BLANK - 1)) state <= ST_DRIVE;
                    count <= count + 1'b1;
                end
                ST_DRIVE: begin
                    if (slot_end) begin
                        state <= ST_BLANK;
                        count <= '0;
                        idx   <= (idx == IW'(N_DIG - 1)) ? '0 : idx + 1'b1;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    count <= '0;
                    idx   <= '0;
                end
            endcase
        end
    end

    // A load on the boundary clock lands in pending after the copy, so it
    // waits for the following frame.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            act_data   <= '0;
            act_dp     <= '0;
            pend_data  <= '0;
            pend_dp    <= '0;
            pend_valid <= 1'b0;
        end else begin
            if (boundary && pend_valid) begin
                act_data <= pend_data;
                act_dp   <= pend_dp;
            end
            if (iLOAD) begin
                pend_data  <= iDATA;
                pend_dp    <= iDP;
                pend_valid <= 1'b1;
            end else if (boundary) begin
                pend_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        nib    = 4'h0;
        dp_sel = 1'b0;
        for (int k = 0; k < N_DIG; k++) begin
            if (idx == IW'(k)) begin
                nib    = act_data[4*k +: 4];
                dp_sel = act_dp[k];
            end
        end
    end

    // Digit k is suppressed when it and every more-significant nibble are zero.
    always_comb begin
        supp     = '0;
        zero_run = 1'b1;
        for (int k = N_DIG - 1; k >= 1; k--) begin
            zero_run = zero_run & (act_data[4*k +: 4] == 4'h0);
            supp[k]  = iLZS & zero_run;
        end
    end

    SEG7_LUT u_lut (
        .iDIG (nib),
        .oSEG (lut_seg)
    );

    always_comb begin
        nxt_seg = SEG_OFF;
        nxt_dp  = 1'b1;
        nxt_com = COM_OFF;
        if (iEN && (state == ST_DRIVE) && !supp[idx]) begin
            nxt_seg      = lut_seg;
            nxt_dp       = ~dp_sel;
            nxt_com[idx] = 1'b0;
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            oSEG   <= SEG_OFF;
            oDP    <= 1'b1;
            oCOM   <= COM_OFF;
            oFRAME <= 1'b0;
        end else begin
            oSEG   <= nxt_seg;
            oDP    <= nxt_dp;
            oCOM   <= nxt_com;
            oFRAME <= iEN && frame_end;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl (N_DIG=4, DIV=8, BLANK=2) against a time-based
// reference model: position in frame = cycles since enable, modulo frame length.
module tb_seg7_scan_ctrl;

    localparam int N_DIG     = 4;
    localparam int DIV       = 8;
    localparam int BLANK     = 2;
    localparam int FRAME_LEN = N_DIG * DIV;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;
    logic        iEN = 1'b0;
    logic        iLOAD = 1'b0;
    logic        iLZS = 1'b0;
    logic [15:0] iDATA = '0;
    logic [3:0]  iDP = '0;
    logic [6:0]  oSEG;
    logic        oDP;
    logic [3:0]  oCOM;
    logic        oFRAME;
    logic [1:0]  dbg_state;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int cyc      = 0;

    bit          m_run;
    int          m_t;
    logic [15:0] m_act, m_pend;
    logic [3:0]  m_act_dp, m_pend_dp;
    bit          m_pv;
    logic [6:0]  seg_tab [16];

    seg7_scan_ctrl #(.N_DIG(N_DIG), .DIV(DIV), .BLANK(BLANK)) dut (
        .iCLK      (iCLK),
        .iRST      (iRST),
        .iEN       (iEN),
        .iDATA     (iDATA),
        .iDP       (iDP),
        .iLOAD     (iLOAD),
        .iLZS      (iLZS),
        .oSEG      (oSEG),
        .oDP       (oDP),
        .oCOM      (oCOM),
        .oFRAME    (oFRAME),
        .dbg_state (dbg_state)
    );

    always #5 iCLK = ~iCLK;

    task automatic model_reset();
        m_run = 0; m_t = 0;
        m_act = '0; m_pend = '0; m_act_dp = '0; m_pend_dp = '0; m_pv = 0;
    endtask

    task automatic model_expect(output logic [6:0] es, output logic edp,
                                output logic [3:0] ecom, output logic efr);
        int slot, idx, pos;
        bit supp;
        logic [3:0] nib;
        es = 7'h7F; edp = 1'b1; ecom = 4'hF; efr = 1'b0;
        if (iEN && m_run) begin
            slot = m_t / DIV;
            idx  = slot % N_DIG;
            pos  = m_t % DIV;
            supp = 0;
            if (iLZS && idx >= 1) begin
                supp = 1;
                for (int k = idx; k < N_DIG; k++)
                    if (((m_act >> (4 * k)) & 16'hF) != 0) supp = 0;
            end
            if (pos >= BLANK && !supp) begin
                nib  = 4'((m_act >> (4 * idx)) & 16'hF);
                es   = seg_tab[nib];
                edp  = ~m_act_dp[idx];
                ecom = 4'hF & ~(4'b0001 << idx);
            end
            efr = (idx == N_DIG - 1) && (pos == DIV - 1);
        end
    endtask

    task automatic model_update();
        bit boundary;
        boundary = iEN && (!m_run || m_t == FRAME_LEN - 1);
        if (boundary && m_pv) begin
            m_act = m_pend; m_act_dp = m_pend_dp;
        end
        if (iLOAD) begin
            m_pend = iDATA; m_pend_dp = iDP; m_pv = 1;
        end else if (boundary) begin
            m_pv = 0;
        end
        if (!iEN) begin
            m_run = 0; m_t = 0;
        end else if (!m_run) begin
            m_run = 1; m_t = 0;
        end else begin
            m_t = (m_t + 1) % FRAME_LEN;
        end
    endtask

    // One clock: predict from model + current inputs, check outputs after the edge.
    task automatic step(input string tag);
        logic [6:0] es;
        logic       edp, efr;
        logic [3:0] ecom;
        model_expect(es, edp, ecom, efr);
        @(posedge iCLK);
        #1;
        cyc++;
        chk_cnt++;
        if (oSEG !== es) $display("FAIL %s seg cyc=%0d got=%b exp=%b", tag, cyc, oSEG, es);
        else pass_cnt++;
        chk_cnt++;
        if (oDP !== edp) $display("FAIL %s dp cyc=%0d got=%b exp=%b", tag, cyc, oDP, edp);
        else pass_cnt++;
        chk_cnt++;
        if (oCOM !== ecom) $display("FAIL %s com cyc=%0d got=%b exp=%b", tag, cyc, oCOM, ecom);
        else pass_cnt++;
        chk_cnt++;
        if (oFRAME !== efr) $display("FAIL %s frame cyc=%0d got=%b exp=%b", tag, cyc, oFRAME, efr);
        else pass_cnt++;
        model_update();
    endtask

    task automatic run(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    task automatic test_reset();
        iRST = 1'b1; iEN = 1'b0; iLOAD = 1'b0;
        model_reset();
        #12 iRST = 1'b0;
        @(posedge iCLK); #1;
        iDATA = 16'h8888; iDP = 4'hF; iLOAD = 1'b1;
        step("rst_load");
        iLOAD = 1'b0; iEN = 1'b1;
        run("rst_run", 13);
        #2 iRST = 1'b1;
        #1;
        model_reset();
        chk_cnt++;
        if ({oSEG, oDP, oCOM, oFRAME} !== {7'h7F, 1'b1, 4'hF, 1'b0})
            $display("FAIL reset_async got seg=%b dp=%b com=%b fr=%b", oSEG, oDP, oCOM, oFRAME);
        else pass_cnt++;
        chk_cnt++;
        if (dbg_state !== 2'd0) $display("FAIL reset_state got=%0d exp=0", dbg_state);
        else pass_cnt++;
        iEN = 1'b0;
        #3 iRST = 1'b0;
        run("reset_idle", 6);
    endtask

    task automatic test_basic();
        int frames[$];
        iDATA = 16'h1234; iDP = 4'b0010; iLOAD = 1'b1;
        step("basic_load");
        iLOAD = 1'b0; iEN = 1'b1;
        for (int i = 0; i < 3 * FRAME_LEN + 2; i++) begin
            step("basic");
            if (oFRAME === 1'b1) frames.push_back(cyc);
        end
        chk_cnt++;
        if (frames.size() < 3) $display("FAIL frame_count got=%0d exp>=3", frames.size());
        else pass_cnt++;
        for (int i = 1; i < frames.size(); i++) begin
            chk_cnt++;
            if (frames[i] - frames[i-1] !== FRAME_LEN)
                $display("FAIL frame_period got=%0d exp=%0d", frames[i] - frames[i-1], FRAME_LEN);
            else pass_cnt++;
        end
    endtask

    task automatic test_lzs();
        iEN = 1'b0;
        step("lzs_off");
        iDATA = 16'h0050; iDP = 4'b1111; iLOAD = 1'b1; iLZS = 1'b1;
        step("lzs_load");
        iLOAD = 1'b0; iEN = 1'b1;
        run("lzs_on", FRAME_LEN + 2);
        iLZS = 1'b0;
        run("lzs_clear", FRAME_LEN);
    endtask

    task automatic test_anti_tear();
        iEN = 1'b0; iLZS = 1'b0;
        step("tear_off");
        iDATA = 16'h1234; iDP = 4'b0000; iLOAD = 1'b1;
        step("tear_load");
        iLOAD = 1'b0; iEN = 1'b1;
        for (int i = 0; i < FRAME_LEN && m_t != DIV + 3; i++) step("tear_seek");
        iDATA = 16'hABCD; iDP = 4'b0001; iLOAD = 1'b1;
        step("tear_mid_load");
        iLOAD = 1'b0;
        run("tear", 2 * FRAME_LEN);
    endtask

    task automatic test_back_to_back();
        iEN = 1'b0;
        step("b2b_off");
        iDATA = 16'hAAAA; iDP = 4'b0101; iLOAD = 1'b1;
        step("b2b_pend");
        iDATA = 16'h5555; iDP = 4'b1010; iEN = 1'b1;
        step("b2b_enable_load");
        iLOAD = 1'b0;
        for (int i = 0; i < FRAME_LEN && m_t != 10; i++) step("b2b_seek");
        iDATA = 16'h7777; iDP = 4'b0011; iLOAD = 1'b1;
        step("b2b_mid");
        iLOAD = 1'b0;
        for (int i = 0; i < FRAME_LEN && m_t != FRAME_LEN - 1; i++) step("b2b_seek_wrap");
        iDATA = 16'h9999; iDP = 4'b1100; iLOAD = 1'b1;
        step("b2b_wrap_load");
        iLOAD = 1'b0;
        run("b2b", 2 * FRAME_LEN + 2);
    endtask

    task automatic test_enable_drop();
        iEN = 1'b1;
        for (int i = 0; i < 2 * FRAME_LEN && m_t != 2 * DIV + BLANK + 1; i++) step("drop_seek");
        iEN = 1'b0;
        step("drop_edge");
        run("drop_idle", 4);
        iEN = 1'b1;
        run("drop_restart", FRAME_LEN + 4);
    endtask

    task automatic test_random();
        logic [15:0] masks [4];
        masks[0] = 16'hFFFF; masks[1] = 16'h00FF; masks[2] = 16'h000F; masks[3] = 16'h0F0F;
        for (int i = 0; i < 1500; i++) begin
            iLOAD = ($urandom_range(0, 11) == 0);
            iDATA = 16'($urandom) & masks[$urandom_range(0, 3)];
            iDP   = 4'($urandom);
            if ($urandom_range(0, 39) == 0) iLZS = ~iLZS;
            if (iEN) iEN = ($urandom_range(0, 79) != 0);
            else     iEN = ($urandom_range(0, 3) == 0);
            step("random");
        end
        iLOAD = 1'b0;
    endtask

    initial begin
        seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        test_reset();
        test_basic();
        test_lzs();
        test_anti_tear();
        test_back_to_back();
        test_enable_drop();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Time-multiplexed scan controller for an N-digit common-anode 7-segment display.
- Shares one hex-to-7-segment decoder (SEG7_LUT) across all digits.
- Sequences digit anodes with a blanking gap between digits to suppress ghosting.
- Double-buffers display data so updates take effect only at frame boundaries (no tearing); optional leading-zero suppression.

Parameters:
N_DIG, 4, number of digits scanned (2..8)
DIV, 50000, clocks per digit slot
BLANK, 4, clocks at start of each slot with all anodes off (1 <= BLANK < DIV)

Ports:
iCLK  in  1  system clock
iRST  in  1  asynchronous active-high reset
iEN  in  1  scan enable; 0 = display dark and scan held at slot 0
iDATA  in  4*N_DIG  hex digits; nibble k = digit k, digit 0 least significant
iDP  in  N_DIG  decimal-point request per digit, 1 = on
iLOAD  in  1  single-cycle strobe; capture iDATA/iDP into pending buffer
iLZS  in  1  leading-zero suppression enable
oSEG  out  7  segment drive, active-low, decoder encoding
oDP  out  1  decimal point, active-low
oCOM  out  N_DIG  anode enables, active-low, at most one low at a time
oFRAME  out  1  one-cycle pulse on the last clock of digit N_DIG-1's slot

Behaviour:
- Clock and reset: one clock iCLK; iRST is asynchronous and active-high.
- Reset values: oSEG=7'h7F, oDP=1, oCOM all 1, oFRAME=0.
  - Slot counter=0, digit index=0, state=IDLE.
  - Active and pending buffers = 0; pending_valid=0.
- States:
  - IDLE: outputs dark; counters held at 0.
    - iEN=1 -> BLANK, digit 0, count 0.
  - BLANK: outputs dark for BLANK clocks (count 0..BLANK-1) -> DRIVE.
  - DRIVE: count BLANK..DIV-1.
    - oCOM[idx]=0.
    - oSEG = decode(active nibble idx).
    - oDP = ~active_dp[idx].
    - At count DIV-1 -> BLANK with idx+1; idx wraps N_DIG-1 -> 0.
  - iEN=0 in any state -> IDLE on the next edge; outputs dark the following cycle.
- All outputs are registered: they reflect the state/idx/count of the previous cycle (1-clock latency). Decoder and mux sit combinationally before the output register.
- Counter width: $clog2(DIV). Digit index width: $clog2(N_DIG), minimum 1.
- Buffering:
  - iLOAD=1: pending <= {iDATA,iDP}; pending_valid <= 1. Last load wins within a frame.
  - Frame boundary = transition into BLANK with idx=0, including IDLE->BLANK.
    - If pending_valid: active <= pending; pending_valid <= 0.
  - iLOAD coinciding with a boundary: the boundary copies the old pending; the new load sets pending_valid and applies at the next boundary.
- Leading-zero suppression, evaluated on the active buffer:
  - Digit k (k >= 1) is suppressed if iLZS=1 and active nibbles k..N_DIG-1 are all 0.
  - Digit 0 is never suppressed.
  - Suppressed digit: oCOM stays all 1, oSEG=7'h7F, oDP=1 for the whole slot. DP request is ignored.
- oFRAME asserts on the clock where state=DRIVE, idx=N_DIG-1, count=DIV-1, and iEN=1.
- iRST mid-slot: immediate dark outputs. Buffers clear, so a scan restarted after reset shows 0 until reloaded.

Decomposition:
- Shared package seg7_pkg holds:
  - state encoding (IDLE, BLANK, DRIVE);
  - SEG_OFF constant 7'h7F;
  - COM_OFF helper for an all-ones anode vector.
- One sub-module: a single instance of the existing SEG7_LUT decoder, fed by the muxed active nibble. No other hierarchy.

Test Plan (N_DIG=4, DIV=8, BLANK=2):
1. Reset: assert iRST mid-run -> same cycle oSEG=7'h7F, oDP=1, oCOM=4'b1111, oFRAME=0; remain so while iEN=0.
2. iLOAD with iDATA=16'h1234, iDP=4'b0010, then iEN=1:
   - Digit-0 drive clocks: oCOM=4'b1110, oSEG=7'b0011001, oDP=1.
   - Digit-1: oCOM=4'b1101, oSEG=7'b0110000, oDP=0.
   - 2 dark clocks precede each slot.
   - oFRAME pulses every 32 clocks.
3. LZS: iDATA=16'h0050, iLZS=1:
   - Digits 3 and 2 slots: oCOM=4'b1111 throughout.
   - Digit 1: oSEG=7'b0010010.
   - Digit 0: oSEG=7'b1000000.
   - With iLZS=0: digits 3 and 2 show 7'b1000000.
4. Anti-tear: active=16'h1234; pulse iLOAD with 16'hABCD during digit-1 slot:
   - Digits 2 and 3 still show 2 and 1 in this frame.
   - Next frame digit 0 shows 7'b0100001 (D).
5. Boundary collision: iLOAD on the exact IDLE->BLANK / wrap clock -> previous pending applies now; the new value applies one frame later.
6. Enable drop: iEN=0 during a digit-2 drive clock -> next cycle oCOM=4'b1111. Re-enable -> scan restarts at digit 0 after 2 blank clocks.
